// File: rtl/capture_pkg.sv
// Shared constants, record type and output-stage state encoding for the capture scheduler.
package capture_pkg;

   localparam int DEF_NCH  = 4;
   localparam int DEF_CW   = 8;
   localparam int DEF_SYNC = 2;
   localparam int CHW      = $clog2(DEF_NCH);

   typedef struct packed {
      logic [CHW-1:0]    chan;
      logic [DEF_CW-1:0] ts;
   } cap_rec_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   // Cyclic successor of v in the range 0..n-1
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/capture_scheduler_rr_arbiter.sv
// NCH-way round-robin arbiter: picks the first requester at or after the pointer, cyclically.
module rr_arbiter
   import capture_pkg::*;
#(
   parameter int NCH = DEF_NCH
) (
   input  logic [NCH-1:0]         i_req,
   input  logic [$clog2(NCH)-1:0] i_ptr,
   output logic [NCH-1:0]         o_grant,
   output logic [$clog2(NCH)-1:0] o_idx,
   output logic                   o_any
);

   localparam int IW = $clog2(NCH);

   int            w_pos;
   logic [IW-1:0] w_idx;

   // Scan from the pointer around the ring; the first request found wins
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_pos   = 0;
      w_idx   = '0;
      for (int k = 0; k < NCH; k++) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= NCH) w_pos = w_pos - NCH;
         w_idx = IW'(w_pos);
         if (!o_any && i_req[w_idx]) begin
            o_any          = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_idx          = w_idx;
         end
      end
   end

endmodule

// File: rtl/capture_scheduler.sv
// Multi-channel input capture: synchronize, rising-edge timestamp into per-channel slots,
// drain slots round-robin into a single valid/ready record port with sticky flags.
module capture_scheduler
   import capture_pkg::*;
#(
   parameter int NCH         = DEF_NCH,
   parameter int CW          = DEF_CW,
   parameter int SYNC_STAGES = DEF_SYNC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         sig,
   input  logic [NCH-1:0]         en,
   output logic                   cap_valid,
   input  logic                   cap_ready,
   output logic [$clog2(NCH)-1:0] cap_chan,
   output logic [CW-1:0]          cap_ts,
   output logic                   int_flag,
   input  logic                   int_clr,
   output logic [NCH-1:0]         ovr,
   input  logic                   ovr_clr
);

   localparam int IW = $clog2(NCH);

   logic [CW-1:0]  r_tb;
   logic [NCH-1:0] r_sync [SYNC_STAGES];
   logic [NCH-1:0] r_prev;
   logic [NCH-1:0] r_pending;
   logic [CW-1:0]  r_slot [NCH];
   logic [IW-1:0]  r_rr_ptr;
   out_state_t     r_state;
   out_state_t     w_state_nxt;
   logic [IW-1:0]  r_cap_chan;
   logic [CW-1:0]  r_cap_ts;
   logic           r_int_flag;
   logic [NCH-1:0] r_ovr;

   logic [NCH-1:0] w_rise;
   logic [NCH-1:0] w_arb_grant;
   logic [NCH-1:0] w_take;
   logic [NCH-1:0] w_ovr_set;
   logic [IW-1:0]  w_arb_idx;
   logic           w_arb_any;
   logic           w_loadable;
   logic           w_do_grant;

   // Free-running timebase, wraps naturally at 2^CW
   always_ff @(posedge clk) begin
      if (rst) r_tb <= '0;
      else     r_tb <= r_tb + CW'(1);
   end

   // Synchronizer chain plus one delayed copy of its output for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= sig;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev & en;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .i_req   (r_pending),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_any   (w_arb_any)
   );

   // Output stage next state: load when empty or when the held record is being taken
   always_comb begin
      w_state_nxt = r_state;
      w_loadable  = (r_state == EMPTY) || cap_ready;
      w_do_grant  = w_loadable && w_arb_any;
      if (w_do_grant)                        w_state_nxt = FULL;
      else if (r_state == FULL && cap_ready) w_state_nxt = EMPTY;
   end

   // A slot granted this cycle may be refilled by a simultaneous rise without overrun
   assign w_take    = w_arb_grant & {NCH{w_do_grant}};
   assign w_ovr_set = w_rise & r_pending & ~w_take;

   // Output stage state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Pending slots: first undelivered timestamp wins, later rises only flag overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
         for (int i = 0; i < NCH; i++) r_slot[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_rise[i] && (!r_pending[i] || w_take[i])) begin
               r_slot[i]    <= r_tb;
               r_pending[i] <= 1'b1;
            end else if (w_take[i]) begin
               r_pending[i] <= 1'b0;
            end
         end
      end
   end

   // Output record and round-robin pointer, updated only on a grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cap_chan <= '0;
         r_cap_ts   <= '0;
         r_rr_ptr   <= '0;
      end else if (w_do_grant) begin
         r_cap_chan <= w_arb_idx;
         r_cap_ts   <= r_slot[w_arb_idx];
         r_rr_ptr   <= IW'(wrap_inc(int'(w_arb_idx), NCH));
      end
   end

   // Sticky flags: a set in the same cycle as a clear takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         r_int_flag <= 1'b0;
         r_ovr      <= '0;
      end else begin
         if (cap_valid && cap_ready) r_int_flag <= 1'b1;
         else if (int_clr)           r_int_flag <= 1'b0;
         r_ovr <= (r_ovr & ~{NCH{ovr_clr}}) | w_ovr_set;
      end
   end

   assign cap_valid = (r_state == FULL);
   assign cap_chan  = r_cap_chan;
   assign cap_ts    = r_cap_ts;
   assign int_flag  = r_int_flag;
   assign ovr       = r_ovr;

endmodule

// File: tb/tb_capture_scheduler.sv
// Randomized and directed bench for capture_scheduler with a behavioural model and scoreboard.
module tb_capture_scheduler;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int S   = 2;

   typedef struct {
      int chan;
      int ts;
   } rec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] sig;
   logic [NCH-1:0] en;
   logic           cap_valid;
   logic           cap_ready;
   logic [1:0]     cap_chan;
   logic [CW-1:0]  cap_ts;
   logic           int_flag;
   logic           int_clr;
   logic [NCH-1:0] ovr;
   logic           ovr_clr;

   int n_checks = 0;
   int n_errors = 0;

   capture_scheduler #(.NCH(NCH), .CW(CW), .SYNC_STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .sig       (sig),
      .en        (en),
      .cap_valid (cap_valid),
      .cap_ready (cap_ready),
      .cap_chan  (cap_chan),
      .cap_ts    (cap_ts),
      .int_flag  (int_flag),
      .int_clr   (int_clr),
      .ovr       (ovr),
      .ovr_clr   (ovr_clr)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [NCH-1:0] hist[$];
   bit   [NCH-1:0] m_pend;
   int             m_slot [NCH];
   bit             m_full;
   bit             m_int;
   logic [NCH-1:0] m_ovr;
   int             m_rr;
   int             m_tb;
   rec_t           exp_q[$];

   logic [NCH-1:0] m_rise;
   bit             m_gnt;
   int             m_g;
   rec_t           m_rec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: an input level reaches the edge detector S edges after it is sampled;
   // each pending channel holds its first unread timestamp; one record drains at a time.
   always @(posedge clk) begin
      if (rst) begin
         hist.delete();
         for (int k = 0; k <= S; k++) hist.push_back('0);
         m_pend = '0;
         for (int i = 0; i < NCH; i++) m_slot[i] = 0;
         m_full = 0;
         m_int  = 0;
         m_ovr  = '0;
         m_rr   = 0;
         m_tb   = 0;
         exp_q.delete();
      end else begin
         m_rise = hist[S-1] & ~hist[S] & en;
         m_gnt  = 0;
         m_g    = 0;
         if (!m_full || cap_ready) begin
            for (int k = 0; k < NCH; k++) begin
               if (!m_gnt && m_pend[(m_rr + k) % NCH]) begin
                  m_gnt = 1;
                  m_g   = (m_rr + k) % NCH;
               end
            end
         end
         if (m_full && cap_ready) m_int = 1;
         else if (int_clr)        m_int = 0;
         if (ovr_clr) m_ovr = '0;
         if (m_gnt) begin
            m_rec.chan = m_g;
            m_rec.ts   = m_slot[m_g];
            exp_q.push_back(m_rec);
            m_full = 1;
            m_rr   = (m_g + 1) % NCH;
         end else if (m_full && cap_ready) begin
            m_full = 0;
         end
         for (int i = 0; i < NCH; i++) begin
            if (m_rise[i]) begin
               if (m_pend[i] && !(m_gnt && m_g == i)) begin
                  m_ovr[i] = 1'b1;
               end else begin
                  m_slot[i] = m_tb;
                  m_pend[i] = 1'b1;
               end
            end else if (m_gnt && m_g == i) begin
               m_pend[i] = 1'b0;
            end
         end
         m_tb = (m_tb + 1) % (1 << CW);
         hist.push_front(sig);
         void'(hist.pop_back());
      end
   end

   // Monitor: compare presented record against the scoreboard head, pop on handshake
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         chk("cap_valid", 32'(cap_valid), 32'(m_full));
         chk("int_flag", 32'(int_flag), 32'(m_int));
         chk("ovr", 32'(ovr), 32'(m_ovr));
         if (cap_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL record_unexpected: got chan %0d ts %0d, expected no record at %0t",
                        cap_chan, cap_ts, $time);
            end else begin
               chk("cap_chan", 32'(cap_chan), 32'(exp_q[0].chan));
               chk("cap_ts", 32'(cap_ts), 32'(exp_q[0].ts));
               if (cap_ready === 1'b1) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      sig = '0; en = '1; cap_ready = 1'b0; int_clr = 1'b0; ovr_clr = 1'b0; rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(cap_valid), 32'd0);
      chk("rst_chan", 32'(cap_chan), 32'd0);
      chk("rst_ts", 32'(cap_ts), 32'd0);
      chk("rst_int", 32'(int_flag), 32'd0);
      chk("rst_ovr", 32'(ovr), 32'd0);

      // Single event sampled while timebase=5 -> stamp 7, valid after third edge
      repeat (5) @(posedge clk);
      #1 sig = 4'b0001; cap_ready = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t1_valid", 32'(cap_valid), 32'd1);
      chk("t1_chan", 32'(cap_chan), 32'd0);
      chk("t1_ts", 32'(cap_ts), 32'd7);
      @(posedge clk);
      #1 sig = '0;
      @(negedge clk);
      chk("t1_int", 32'(int_flag), 32'd1);
      step(6);

      // Simultaneous events, round-robin order from the pointer
      sig = 4'b0001; step(2); sig = '0; step(8);
      sig = 4'b1111; step(2); sig = '0; step(10);
      sig = 4'b1111; step(2); sig = '0; step(10);

      // Backpressure and overrun on channel 2
      cap_ready = 1'b0;
      for (int p = 0; p < 3; p++) begin
         sig = 4'b0100; step(2); sig = '0; step(3);
      end
      step(3);
      @(negedge clk);
      chk("t3_ovr2", 32'(ovr[2]), 32'd1);
      chk("t3_held", 32'(cap_valid), 32'd1);
      step(1);
      cap_ready = 1'b1; step(4);
      ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
      @(negedge clk);
      chk("t3_ovr_clr", 32'(ovr), 32'd0);
      step(4);

      // Timestamp wrap: stamps 255 then 2
      n = 0;
      while (m_tb != 253 && n < 300) begin step(1); n++; end
      sig = 4'b0001; step(3);
      sig = 4'b0011; step(2);
      sig = '0; step(8);

      // Clear colliding with an accepted record, then disabled channel activity
      cap_ready = 1'b0;
      sig = 4'b1000; step(2); sig = '0; step(6);
      int_clr = 1'b1; step(1); int_clr = 1'b0;
      cap_ready = 1'b1; int_clr = 1'b1; step(1); int_clr = 1'b0;
      @(negedge clk);
      chk("t5_int_sticky", 32'(int_flag), 32'd1);
      step(2);
      en = 4'b1101;
      for (int p = 0; p < 4; p++) begin
         sig = 4'b0010; step(3); sig = '0; step(3);
      end
      @(negedge clk);
      chk("t5_en_valid", 32'(cap_valid), 32'd0);
      chk("t5_en_ovr", 32'(ovr), 32'd0);
      step(1);
      en = '1;

      // Reset while a record is held and three slots are pending
      cap_ready = 1'b0;
      sig = 4'b1111; step(2); sig = '0; step(6);
      n = 0;
      while (cap_valid !== 1'b1 && n < 20) begin step(1); n++; end
      chk("t6_pre_valid", 32'(cap_valid), 32'd1);
      rst = 1'b1; step(1); rst = 1'b0;
      @(negedge clk);
      chk("t6_valid", 32'(cap_valid), 32'd0);
      chk("t6_chan", 32'(cap_chan), 32'd0);
      chk("t6_ts", 32'(cap_ts), 32'd0);
      chk("t6_int", 32'(int_flag), 32'd0);
      chk("t6_ovr", 32'(ovr), 32'd0);
      step(1);
      cap_ready = 1'b1; step(10);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         sig       = sig ^ NCH'($urandom & $urandom);
         en        = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
         cap_ready = ($urandom_range(0, 3) != 0);
         int_clr   = ($urandom_range(0, 9) == 0);
         ovr_clr   = ($urandom_range(0, 19) == 0);
         step(1);
      end

      // Drain
      sig = '0; en = '1; cap_ready = 1'b1; int_clr = 1'b0; ovr_clr = 1'b0;
      step(20);
      @(negedge clk);
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      chk("drain_valid", 32'(cap_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
